// File: rtl/dmem_access_unit.sv
// RV32I memory-stage load/store unit: aligns stores onto a word-addressed
// data-memory port, formats load data, and stalls the pipeline until the access retires.
module dmem_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic        dmem_read_i,
    input  logic        dmem_write_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] store_data_i,
    output logic [31:0] dmem_address,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [3:0]  dmem_mbe,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_resp,
    output logic        stall_o,
    output logic [31:0] load_data_o,
    output logic        load_valid_o,
    output logic        err_o
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state, state_next;
    logic              op_c, bad_c, accept_c, complete_c;
    logic [3:0]        mbe_c;
    logic [2:0]        funct3_q;
    logic [1:0]        offset_q;
    logic              is_load_q;
    logic [XLEN-1:0]   rdata_shift_c, load_fmt_c;

    assign op_c = valid_i & (dmem_read_i | dmem_write_i);

    // Reject conflicting controls, unknown widths and misaligned halves/words.
    always_comb begin
        bad_c = 1'b0;
        if (dmem_read_i && dmem_write_i) begin
            bad_c = 1'b1;
        end else if (dmem_read_i) begin
            case (funct3_i)
                3'd0, 3'd4: bad_c = 1'b0;
                3'd1, 3'd5: bad_c = addr_i[0];
                3'd2:       bad_c = (addr_i[1:0] != 2'b00);
                default:    bad_c = 1'b1;
            endcase
        end else if (dmem_write_i) begin
            case (funct3_i)
                3'd0:    bad_c = 1'b0;
                3'd1:    bad_c = addr_i[0];
                3'd2:    bad_c = (addr_i[1:0] != 2'b00);
                default: bad_c = 1'b1;
            endcase
        end
    end

    always_comb begin
        case (funct3_i[1:0])
            2'd0:    mbe_c = 4'b0001 << addr_i[1:0];
            2'd1:    mbe_c = 4'b0011 << addr_i[1:0];
            default: mbe_c = 4'b1111;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        stall_o    = 1'b0;
        err_o      = 1'b0;
        accept_c   = 1'b0;
        complete_c = 1'b0;
        case (state)
            IDLE: begin
                if (op_c) begin
                    if (bad_c) begin
                        err_o = 1'b1;
                    end else begin
                        accept_c   = 1'b1;
                        stall_o    = 1'b1;
                        state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                stall_o = 1'b1;
                if (dmem_resp) begin
                    complete_c = 1'b1;
                    state_next = DONE;
                end
            end
            // Inputs still describe the retiring instruction here; ignore them.
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign rdata_shift_c = dmem_rdata >> {offset_q, 3'b000};

    always_comb begin
        case (funct3_q)
            3'd0:    load_fmt_c = {{24{rdata_shift_c[7]}}, rdata_shift_c[7:0]};
            3'd1:    load_fmt_c = {{16{rdata_shift_c[15]}}, rdata_shift_c[15:0]};
            3'd4:    load_fmt_c = {24'd0, rdata_shift_c[7:0]};
            3'd5:    load_fmt_c = {16'd0, rdata_shift_c[15:0]};
            default: load_fmt_c = dmem_rdata;
        endcase
    end

    // Request capture on acceptance, request release and load capture on response.
    always_ff @(posedge clk) begin
        if (rst) begin
            dmem_address <= '0;
            dmem_mbe     <= 4'b0000;
            dmem_wdata   <= '0;
            dmem_read    <= 1'b0;
            dmem_write   <= 1'b0;
            funct3_q     <= 3'd0;
            offset_q     <= 2'd0;
            is_load_q    <= 1'b0;
            load_valid_o <= 1'b0;
            load_data_o  <= '0;
        end else begin
            if (accept_c) begin
                dmem_address <= {addr_i[31:2], 2'b00};
                dmem_mbe     <= mbe_c;
                dmem_wdata   <= store_data_i << {addr_i[1:0], 3'b000};
                funct3_q     <= funct3_i;
                offset_q     <= addr_i[1:0];
                is_load_q    <= dmem_read_i;
                dmem_read    <= dmem_read_i;
                dmem_write   <= dmem_write_i;
            end else if (complete_c) begin
                dmem_read    <= 1'b0;
                dmem_write   <= 1'b0;
            end
            load_valid_o <= complete_c & is_load_q;
            if (complete_c && is_load_q) begin
                load_data_o <= load_fmt_c;
            end
        end
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Scoreboard bench for dmem_access_unit: driver queues expected requests,
// loads and errors; a monitor pops and compares as the DUT presents them.
module tb_dmem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i, dmem_read_i, dmem_write_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i, store_data_i;
    logic [31:0] dmem_address, dmem_wdata, dmem_rdata, load_data_o;
    logic        dmem_read, dmem_write, dmem_resp;
    logic        stall_o, load_valid_o, err_o;
    logic [3:0]  dmem_mbe;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  mbe;
        logic [31:0] wdata;
    } req_t;

    req_t        req_q[$];
    logic [31:0] load_q[$];
    int          err_q[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    bit          mon_en = 1'b0;
    bit          prev_req = 1'b0;
    req_t        cur_exp;
    logic [31:0] exp_last_load = 32'd0;

    always #5 clk = ~clk;

    dmem_access_unit dut (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (valid_i),
        .dmem_read_i  (dmem_read_i),
        .dmem_write_i (dmem_write_i),
        .funct3_i     (funct3_i),
        .addr_i       (addr_i),
        .store_data_i (store_data_i),
        .dmem_address (dmem_address),
        .dmem_read    (dmem_read),
        .dmem_write   (dmem_write),
        .dmem_mbe     (dmem_mbe),
        .dmem_wdata   (dmem_wdata),
        .dmem_rdata   (dmem_rdata),
        .dmem_resp    (dmem_resp),
        .stall_o      (stall_o),
        .load_data_o  (load_data_o),
        .load_valid_o (load_valid_o),
        .err_o        (err_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: unexpected DUT event at %0t", name, $time);
    endtask

    // Reference model: access size in bytes and legality from the ISA rules.
    function automatic int m_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit m_bad(input bit rd, input bit wr, input logic [2:0] f3,
                                 input logic [31:0] addr);
        if (rd && wr) return 1'b1;
        if (rd && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
        if (wr && f3 > 3'd2) return 1'b1;
        return (int'(addr[1:0]) % m_size(f3)) != 0;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] rdata);
        int          sz;
        int          lo;
        logic [31:0] mask;
        logic [31:0] v;
        sz = m_size(f3);
        lo = int'(addr[1:0]);
        if (sz == 4) return rdata;
        mask = (32'd1 << (8 * sz)) - 32'd1;
        v    = (rdata >> (8 * lo)) & mask;
        if (!f3[2] && v[8 * sz - 1]) v = v | ~mask;
        return v;
    endfunction

    task automatic do_op(input bit rd, input bit wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [31:0] rdata, input int waits);
        bit   bad;
        int   lo;
        int   sz;
        int   stalls;
        req_t r;
        bad    = m_bad(rd, wr, f3, addr);
        lo     = int'(addr[1:0]);
        sz     = m_size(f3);
        stalls = 0;
        @(posedge clk); #1;
        valid_i      = 1'b1;
        dmem_read_i  = rd;
        dmem_write_i = wr;
        funct3_i     = f3;
        addr_i       = addr;
        store_data_i = data;
        dmem_resp    = 1'($urandom_range(0, 1));
        dmem_rdata   = $urandom;
        if (bad) begin
            err_q.push_back(1);
            @(negedge clk);
            chk("stall_on_err", 32'(stall_o), 32'd0);
            return;
        end
        r.rd    = rd;
        r.wr    = wr;
        r.addr  = {addr[31:2], 2'b00};
        r.mbe   = 4'(((1 << sz) - 1) << lo);
        r.wdata = data << (8 * lo);
        req_q.push_back(r);
        if (rd) load_q.push_back(m_load(f3, addr, rdata));
        @(negedge clk);
        if (stall_o) stalls++;
        for (int k = 0; k <= waits; k++) begin
            @(posedge clk); #1;
            dmem_resp  = (k == waits);
            dmem_rdata = (k == waits) ? rdata : $urandom;
            @(negedge clk);
            if (stall_o) stalls++;
        end
        @(posedge clk); #1;
        dmem_resp  = 1'($urandom_range(0, 1));
        dmem_rdata = $urandom;
        @(negedge clk);
        if (stall_o) stalls++;
        chk("stall_cycles", 32'(stalls), 32'(2 + waits));
    endtask

    task automatic nop();
        @(posedge clk); #1;
        valid_i = 1'($urandom_range(0, 1));
        if (valid_i) begin
            dmem_read_i  = 1'b0;
            dmem_write_i = 1'b0;
        end else begin
            dmem_read_i  = 1'($urandom_range(0, 1));
            dmem_write_i = 1'($urandom_range(0, 1));
        end
        funct3_i     = 3'($urandom_range(0, 7));
        addr_i       = $urandom;
        store_data_i = $urandom;
        dmem_resp    = 1'($urandom_range(0, 1));
        dmem_rdata   = $urandom;
        @(negedge clk);
        chk("nop_stall", 32'(stall_o), 32'd0);
        chk("nop_err", 32'(err_o), 32'd0);
    endtask

    // lw accepted, reset in its second BUSY cycle, then a late response.
    task automatic reset_mid_busy();
        req_t r;
        @(posedge clk); #1;
        valid_i      = 1'b1;
        dmem_read_i  = 1'b1;
        dmem_write_i = 1'b0;
        funct3_i     = 3'd2;
        addr_i       = 32'h0000_0400;
        dmem_resp    = 1'b0;
        r.rd    = 1'b1;
        r.wr    = 1'b0;
        r.addr  = 32'h0000_0400;
        r.mbe   = 4'b1111;
        r.wdata = 32'd0;
        req_q.push_back(r);
        @(posedge clk); #1;
        dmem_resp = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst           = 1'b0;
        valid_i       = 1'b0;
        dmem_resp     = 1'b1;
        dmem_rdata    = 32'h1234_5678;
        exp_last_load = 32'd0;
        @(negedge clk);
        chk("rst_dmem_read", 32'(dmem_read), 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        @(posedge clk); #1;
        dmem_resp = 1'b0;
        @(negedge clk);
        chk("rst_no_load_valid", 32'(load_valid_o), 32'd0);
        chk("rst_late_resp_stall", 32'(stall_o), 32'd0);
    endtask

    // Monitor: pops expectations whenever the DUT presents a request, load or error.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (dmem_read || dmem_write) begin
                    if (!prev_req) begin
                        if (req_q.size() == 0) begin
                            flag("unexpected_request");
                        end else begin
                            cur_exp = req_q.pop_front();
                            chk("req_read", 32'(dmem_read), 32'(cur_exp.rd));
                            chk("req_write", 32'(dmem_write), 32'(cur_exp.wr));
                            chk("req_address", dmem_address, cur_exp.addr);
                            if (cur_exp.wr) begin
                                chk("req_mbe", 32'(dmem_mbe), 32'(cur_exp.mbe));
                                chk("req_wdata", dmem_wdata, cur_exp.wdata);
                            end
                        end
                    end else begin
                        chk("busy_hold_address", dmem_address, cur_exp.addr);
                        chk("busy_hold_rw", 32'({dmem_read, dmem_write}),
                            32'({cur_exp.rd, cur_exp.wr}));
                    end
                end
                prev_req = dmem_read || dmem_write;
                if (load_valid_o) begin
                    if (load_q.size() == 0) flag("unexpected_load_valid");
                    else exp_last_load = load_q.pop_front();
                end
                chk("load_data", load_data_o, exp_last_load);
                if (err_o) begin
                    if (err_q.size() == 0) flag("unexpected_err");
                    else begin
                        void'(err_q.pop_front());
                        n_cmp++;
                    end
                end
            end
        end
    end

    initial begin
        int          kind;
        bit          rd, wr;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [2:0]  legal_f3[5];
        legal_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        rst          = 1'b1;
        valid_i      = 1'b0;
        dmem_read_i  = 1'b0;
        dmem_write_i = 1'b0;
        funct3_i     = 3'd0;
        addr_i       = 32'd0;
        store_data_i = 32'd0;
        dmem_rdata   = 32'd0;
        dmem_resp    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_dmem_read", 32'(dmem_read), 32'd0);
        chk("reset_dmem_write", 32'(dmem_write), 32'd0);
        chk("reset_dmem_mbe", 32'(dmem_mbe), 32'd0);
        chk("reset_dmem_address", dmem_address, 32'd0);
        chk("reset_dmem_wdata", dmem_wdata, 32'd0);
        chk("reset_load_data", load_data_o, 32'd0);
        chk("reset_load_valid", 32'(load_valid_o), 32'd0);
        chk("reset_err", 32'(err_o), 32'd0);
        chk("reset_stall", 32'(stall_o), 32'd0);
        @(posedge clk); #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        do_op(1'b0, 1'b1, 3'd2, 32'h0000_0100, 32'hDEAD_BEEF, 32'd0, 2);
        do_op(1'b0, 1'b1, 3'd0, 32'h0000_0103, 32'h0000_00A5, 32'd0, 0);
        do_op(1'b1, 1'b0, 3'd0, 32'h0000_0202, 32'd0, 32'h0080_FF00, 0);
        do_op(1'b1, 1'b0, 3'd4, 32'h0000_0202, 32'd0, 32'h0080_FF00, 1);
        do_op(1'b1, 1'b0, 3'd1, 32'h0000_0301, 32'd0, 32'd0, 0);
        do_op(1'b1, 1'b0, 3'd2, 32'h0000_03F5, 32'd0, 32'd0, 0);
        do_op(1'b1, 1'b1, 3'd2, 32'h0000_0500, 32'd0, 32'd0, 0);
        do_op(1'b0, 1'b1, 3'd4, 32'h0000_0500, 32'd0, 32'd0, 0);
        nop();
        reset_mid_busy();

        for (int i = 0; i < 400; i++) begin
            kind = int'($urandom_range(0, 99));
            if (kind < 10) begin
                nop();
            end else begin
                if (kind < 55)      begin rd = 1'b1; wr = 1'b0; end
                else if (kind < 92) begin rd = 1'b0; wr = 1'b1; end
                else                begin rd = 1'b1; wr = 1'b1; end
                if ($urandom_range(0, 9) < 8) f3 = legal_f3[$urandom_range(0, 4)];
                else f3 = 3'($urandom_range(0, 7));
                a = $urandom;
                do_op(rd, wr, f3, a, $urandom, $urandom, int'($urandom_range(0, 3)));
            end
        end
        nop();
        nop();

        chk("req_queue_drained", 32'(req_q.size()), 32'd0);
        chk("load_queue_drained", 32'(load_q.size()), 32'd0);
        chk("err_queue_drained", 32'(err_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_access_unit.md
# dmem_access_unit

Memory-stage load/store unit for the RV32I pipeline. It takes the decoded memory controls (`dmem_read`, `dmem_write`, `funct3`), the ALU-computed address and the rs2 store data. It drives a word-addressed data-memory port with a request/response handshake and stalls the pipeline until the access completes. Load data is returned sign- or zero-extended for write-back.

## Interface
- Parameters: none; data and address widths are fixed at 32.
- Clock/reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  pipeline clock
- `rst`  in  1  synchronous, active-high reset
- `valid_i`  in  1  memory-stage instruction valid; inputs are held stable while `stall_o`=1
- `dmem_read_i`  in  1  load requested (from control word)
- `dmem_write_i`  in  1  store requested (from control word)
- `funct3_i`  in  3  load/store width: lb/sb=0, lh/sh=1, lw/sw=2, lbu=4, lhu=5
- `addr_i`  in  32  byte address (ALU output)
- `store_data_i`  in  32  rs2 value
- `dmem_address`  out  32  word-aligned address, `{addr[31:2],2'b00}`
- `dmem_read`  out  1  read request, registered
- `dmem_write`  out  1  write request, registered
- `dmem_mbe`  out  4  byte enables
- `dmem_wdata`  out  32  lane-aligned write data
- `dmem_rdata`  in  32  read data, valid with `dmem_resp`
- `dmem_resp`  in  1  access complete
- `stall_o`  out  1  freeze the pipeline (combinational)
- `load_data_o`  out  32  extended load result
- `load_valid_o`  out  1  `load_data_o` is valid this cycle
- `err_o`  out  1  misaligned or illegal access rejected (combinational)

## Operation
- FSM states: IDLE, BUSY, DONE.
- Define `op = valid_i & (dmem_read_i | dmem_write_i)`.
- Define `bad` as true for any of:
  - both read and write set;
  - load with funct3 in {3,6,7};
  - store with funct3 > 2;
  - halfword access with `addr[0]`=1;
  - word access with `addr[1:0]`≠0.
- IDLE, `op & bad`: `err_o`=1 and `stall_o`=0. No request is issued and the state stays IDLE.
- IDLE, `op & !bad`: the address, mbe, wdata, funct3, `addr[1:0]` and request type are registered. `stall_o`=1 and the FSM moves to BUSY.
- BUSY: `dmem_read` or `dmem_write` is asserted from registered values and `stall_o`=1. On `dmem_resp`:
  - requests drop next cycle;
  - for a load, the formatted `dmem_rdata` is captured;
  - the FSM moves to DONE.
- DONE: `stall_o`=0, and `load_valid_o`=1 if the access was a load. Inputs are ignored because they still show the retiring instruction. The FSM always returns to IDLE.
- Byte enables:
  - sb: `4'b0001 << addr[1:0]`
  - sh: `4'b0011 << addr[1:0]`
  - sw: `4'b1111`
- Write data: `store_data_i << (8*addr[1:0])`.
- Load formatting:
  - The byte or half is selected by `addr[1:0]`.
  - lb/lh are sign-extended; lbu/lhu are zero-extended; lw passes through.
- `dmem_resp` is ignored in IDLE and DONE.
- `load_data_o` holds its last value outside DONE.

## Timing
- Reset values:
  - state IDLE;
  - `dmem_read`, `dmem_write`, `load_valid_o`, `err_o` = 0;
  - `dmem_mbe`=4'b0000;
  - `dmem_address`, `dmem_wdata`, `load_data_o` = 0.
- The request appears on the port one cycle after acceptance (cycle A+1).
- `dmem_resp` may be sampled in the first BUSY cycle (zero-wait memory). Minimum occupancy is therefore 3 cycles: A (stall), A+1 (stall), A+2 (DONE, advance).
- Latency to DONE is `2 + wait cycles`. `stall_o` is high for every cycle from A until the cycle `dmem_resp` is sampled.
- Request outputs stay constant throughout BUSY; the memory may take an unbounded time to respond.
- If `rst` is asserted in any state, the FSM is in IDLE and requests are 0 on the next cycle. A late `dmem_resp` after reset is ignored.
- If `err_o` and `valid_i` drop in the same cycle, there is no effect.
- Back-to-back memory ops: the next op is accepted in the IDLE cycle that follows DONE.

## Test plan
- sw, addr=0x100, data=0xDEADBEEF, resp after 2 wait cycles:
  - `dmem_write`=1, `dmem_address`=0x100, `dmem_mbe`=1111, `dmem_wdata`=0xDEADBEEF;
  - `stall_o` high 4 cycles, then DONE.
- sb, addr=0x103, data=0x000000A5, zero-wait:
  - `dmem_mbe`=1000, `dmem_wdata`[31:24]=0xA5, `dmem_address`=0x100;
  - 3-cycle occupancy.
- lb vs lbu, addr=0x202, rdata=0x0080FF00:
  - lb → `load_data_o`=0xFFFFFF80 with `load_valid_o`=1 for one cycle;
  - lbu → 0x00000080.
- lh, addr=0x301 → `err_o`=1, no `dmem_read`, `stall_o`=0.
- lw, addr=0x3F5 → `err_o`=1, no request.
- lw issued, `rst` in the 2nd BUSY cycle, `dmem_resp` arrives one cycle later:
  - state is IDLE, `dmem_read`=0;
  - no `load_valid_o`, and the late `dmem_resp` is ignored.
